// File: rtl/bin_to_seg7_display_pkg.sv
// Shared definitions for the decimal display driver: FSM states and
// active-high seven-segment glyph patterns (bit 0 = segment a .. bit 6 = g).
package bin_to_seg7_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [6:0] GLYPH_0     = 7'b0111111;
  localparam logic [6:0] GLYPH_1     = 7'b0000110;
  localparam logic [6:0] GLYPH_2     = 7'b1011011;
  localparam logic [6:0] GLYPH_3     = 7'b1001111;
  localparam logic [6:0] GLYPH_4     = 7'b1100110;
  localparam logic [6:0] GLYPH_5     = 7'b1101101;
  localparam logic [6:0] GLYPH_6     = 7'b1111101;
  localparam logic [6:0] GLYPH_7     = 7'b0000111;
  localparam logic [6:0] GLYPH_8     = 7'b1111111;
  localparam logic [6:0] GLYPH_9     = 7'b1101111;
  localparam logic [6:0] GLYPH_DASH  = 7'b1000000;
  localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

  // Active-high glyph for one BCD digit; non-decimal codes show nothing.
  function automatic logic [6:0] glyph_of(input logic [3:0] digit);
    logic [6:0] g;
    case (digit)
      4'd0:    g = GLYPH_0;
      4'd1:    g = GLYPH_1;
      4'd2:    g = GLYPH_2;
      4'd3:    g = GLYPH_3;
      4'd4:    g = GLYPH_4;
      4'd5:    g = GLYPH_5;
      4'd6:    g = GLYPH_6;
      4'd7:    g = GLYPH_7;
      4'd8:    g = GLYPH_8;
      4'd9:    g = GLYPH_9;
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bin_to_seg7_display_glyph.sv
// Combinational single-digit glyph decoder with dash/blank override and
// selectable output polarity.
module seg7_glyph
  import bin_to_seg7_display_pkg::*;
#(
  parameter int ACTIVE_LOW = 1
) (
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  input  logic       i_dash,
  output logic [6:0] o_seg
);

  logic [6:0] w_hi;

  // Pick the active-high pattern; dash wins over blank, blank over the digit.
  always_comb begin
    w_hi = glyph_of(i_digit);
    if (i_dash) begin
      w_hi = GLYPH_DASH;
    end else if (i_blank) begin
      w_hi = GLYPH_BLANK;
    end
  end

  assign o_seg = (ACTIVE_LOW != 0) ? ~w_hi : w_hi;

endmodule

// File: rtl/bin_to_seg7_display.sv
// Sequential binary-to-BCD converter (shift-and-add-3) with start/done
// handshake, sticky overflow, leading-zero blanking and registered glyphs.
module bin_to_seg7_display
  import bin_to_seg7_display_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DIGITS     = 3,
  parameter int ACTIVE_LOW = 1,
  parameter int BLANK_LZ   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SEG_W = 7 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [SEG_W-1:0] SEG_OFF  = (ACTIVE_LOW != 0) ? '1 : '0;

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_binreg;
  logic [BCD_W-1:0]   r_work;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_ovf;
  logic [SEG_W-1:0]   r_seg;

  logic               w_accept;
  logic               w_shift;
  logic               w_last;
  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W-1:0]   w_work_next;
  logic               w_carry_next;
  logic [DIGITS-1:0]  w_blank;
  logic               w_zero_above;
  logic [SEG_W-1:0]   w_glyph;

  assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_shift  = (r_state == ST_SHIFT);
  assign w_last   = w_shift && (r_cnt == LAST_CNT);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state: a held start chains DONE straight into the next SHIFT.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_next = ST_SHIFT;
      ST_SHIFT: if (r_cnt == LAST_CNT) w_state_next = ST_DONE;
      ST_DONE:  w_state_next = start ? ST_SHIFT : ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Per-digit +3 correction on 4-bit lanes, then one-bit left shift of
  // {bcd, binreg}; a 1 leaving the top digit is latched as overflow.
  always_comb begin
    w_adj = r_work;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r_work[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_work[4*i +: 4] + 4'd3;
      end
    end
    w_work_next  = {w_adj[BCD_W-2:0], r_binreg[WIDTH-1]};
    w_carry_next = r_carry | w_adj[BCD_W-1];
  end

  // Leading-zero blanking of the post-shift value, scanned from the top
  // digit down; digit 0 is never blanked and overflow disables blanking.
  always_comb begin
    w_blank      = '0;
    w_zero_above = 1'b1;
    for (int unsigned k = 0; k < DIGITS - 1; k++) begin
      w_zero_above = w_zero_above & (w_work_next[4*(DIGITS-1-k) +: 4] == 4'd0);
      w_blank[DIGITS-1-k] = (BLANK_LZ != 0) && !w_carry_next && w_zero_above;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_glyph
    seg7_glyph #(
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_glyph (
      .i_digit (w_work_next[4*g +: 4]),
      .i_blank (w_blank[g]),
      .i_dash  (w_carry_next),
      .o_seg   (w_glyph[7*g +: 7])
    );
  end

  // Conversion engine: load on accept, iterate while shifting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_binreg <= '0;
      r_work   <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_binreg <= bin;
      r_work   <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
    end else if (w_shift) begin
      r_binreg <= r_binreg << 1;
      r_work   <= w_work_next;
      r_carry  <= w_carry_next;
      r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

  // Result registers: captured from the post-shift value on the final
  // iteration so they change together with entry into DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd <= '0;
      r_ovf <= 1'b0;
      r_seg <= SEG_OFF;
    end else if (w_last) begin
      r_bcd <= w_work_next;
      r_ovf <= w_carry_next;
      r_seg <= w_glyph;
    end
  end

  assign busy     = w_shift;
  assign done     = (r_state == ST_DONE);
  assign overflow = r_ovf;
  assign bcd      = r_bcd;
  assign seg      = r_seg;

endmodule

// File: tb/tb_bin_to_seg7_display.sv
// Self-checking bench: two instances (3 digits and 2 digits, 8-bit input,
// active-low, blanking on) driven by the same stimulus and compared every
// cycle against an arithmetic reference model.
module tb_bin_to_seg7_display;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  bin   = 8'd0;

  logic        busy1, done1, ovf1;
  logic [11:0] bcd1;
  logic [20:0] seg1;
  logic        busy2, done2, ovf2;
  logic [7:0]  bcd2;
  logic [13:0] seg2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bin_to_seg7_display #(.WIDTH(8), .DIGITS(3), .ACTIVE_LOW(1), .BLANK_LZ(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy1), .done(done1), .overflow(ovf1), .bcd(bcd1), .seg(seg1)
  );

  bin_to_seg7_display #(.WIDTH(8), .DIGITS(2), .ACTIVE_LOW(1), .BLANK_LZ(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy2), .done(done2), .overflow(ovf2), .bcd(bcd2), .seg(seg2)
  );

  // Active-high digit shapes, bit 0 = a .. bit 6 = g.
  logic [6:0] GL [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                          7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint p10(input int n);
    longint r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [39:0] exp_bcd(input longint v, input int nd);
    logic [39:0] r = '0;
    for (int i = 0; i < nd; i++) r[4*i +: 4] = 4'((v / p10(i)) % 10);
    return r;
  endfunction

  function automatic logic [69:0] exp_seg(input longint v, input int nd);
    logic [69:0] r = '0;
    logic [6:0]  g;
    for (int i = 0; i < nd; i++) begin
      if (v >= p10(nd))               g = 7'b1000000;
      else if (i > 0 && v < p10(i))   g = 7'b0000000;
      else                            g = GL[int'((v / p10(i)) % 10)];
      r[7*i +: 7] = ~g;
    end
    return r;
  endfunction

  // Reference timing model: a conversion occupies 8 edges after acceptance,
  // then its result is visible together with a one-cycle done.
  int     m_rem  = 0;
  bit     m_done = 1'b0;
  bit     m_has  = 1'b0;
  longint m_in   = 0;
  longint m_out  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem = 0; m_done = 1'b0; m_has = 1'b0; m_out = 0;
    end else if (m_rem > 0) begin
      m_rem  = m_rem - 1;
      m_done = 1'b0;
      if (m_rem == 0) begin
        m_done = 1'b1; m_has = 1'b1; m_out = m_in;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_in  = longint'(bin);
        m_rem = 8;
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(posedge clk) begin
    logic [39:0] eb1, eb2;
    logic [69:0] es1, es2;
    #1;
    eb1 = m_has ? exp_bcd(m_out, 3) : '0;
    eb2 = m_has ? exp_bcd(m_out, 2) : '0;
    es1 = m_has ? exp_seg(m_out, 3) : '1;
    es2 = m_has ? exp_seg(m_out, 2) : '1;
    chk("busy1", 70'(busy1), 70'(m_rem > 0));
    chk("done1", 70'(done1), 70'(m_done));
    chk("ovf1",  70'(ovf1),  70'(m_has && m_out >= 1000));
    chk("bcd1",  70'(bcd1),  70'(eb1[11:0]));
    chk("seg1",  70'(seg1),  70'(es1[20:0]));
    chk("busy2", 70'(busy2), 70'(m_rem > 0));
    chk("done2", 70'(done2), 70'(m_done));
    chk("ovf2",  70'(ovf2),  70'(m_has && m_out >= 100));
    chk("bcd2",  70'(bcd2),  70'(eb2[7:0]));
    chk("seg2",  70'(seg2),  70'(es2[13:0]));
  end

  // Request one conversion and count edges (accept edge included) until done.
  task automatic convert(input logic [7:0] v, input int glitch, output int lat);
    @(negedge clk);
    start = 1'b1; bin = v;
    @(posedge clk); #1;
    start = 1'b0; bin = 8'($urandom);
    lat = 1;
    while (1) begin
      @(posedge clk); #1;
      lat++;
      start = (lat == glitch);
      if (lat == glitch) bin = 8'd123;
      if (done1) break;
      if (lat > 40) begin
        n_cmp++; n_err++;
        $display("FAIL done_timeout: no done after %0d edges", lat);
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int lat;
    int dn;
    #100000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int dn;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 70'(busy1), 70'(0));
    chk("rst_done", 70'(done1), 70'(0));
    chk("rst_bcd",  70'(bcd1),  70'(0));
    chk("rst_seg1", 70'(seg1),  70'(21'h1FFFFF));
    chk("rst_seg2", 70'(seg2),  70'(14'h3FFF));
    @(negedge clk) rst_n = 1'b1;

    convert(8'd255, 0, lat);
    chk("lat255",  70'(lat),        70'(9));
    chk("bcd255",  70'(bcd1),       70'(12'h255));
    chk("seg255d2", 70'(seg1[20:14]), 70'(7'b0100100));
    chk("seg255d0", 70'(seg1[6:0]),   70'(7'b0010010));

    convert(8'd7, 0, lat);
    chk("bcd7",    70'(bcd1),       70'(12'h007));
    chk("seg7hi",  70'(seg1[20:7]), 70'(14'h3FFF));
    chk("seg7d0",  70'(seg1[6:0]),  70'(7'b1111000));

    convert(8'd0, 0, lat);
    chk("seg0",    70'(seg1),       70'({7'h7F, 7'h7F, 7'b1000000}));

    convert(8'd100, 0, lat);
    chk("ovf100",  70'(ovf2),       70'(1));
    chk("seg100d", 70'(seg2),       70'({7'b0111111, 7'b0111111}));
    chk("bcd100t", 70'(bcd2),       70'(8'h00));
    chk("seg100w", 70'(seg1),       70'({7'b1111001, 7'b1000000, 7'b1000000}));

    convert(8'd99, 0, lat);
    chk("ovf99",   70'(ovf2),       70'(0));
    chk("bcd99",   70'(bcd2),       70'(8'h99));

    // start pulsed mid-conversion must not disturb result or timing
    convert(8'd50, 4, lat);
    chk("lat_glitch", 70'(lat),     70'(9));
    chk("bcd_glitch", 70'(bcd1),    70'(12'h050));

    // start held high: three back-to-back conversions
    @(negedge clk);
    start = 1'b1; bin = 8'd123;
    @(posedge clk);
    dn = 0;
    for (int k = 1; k <= 26; k++) begin
      @(posedge clk); #1;
      if (k == 4) bin = 8'd45;
      if (done1) begin
        chk("b2b_pos", 70'(k), 70'(8 + 9 * dn));
        dn++;
      end
    end
    @(negedge clk) start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done1) dn++;
    end
    chk("b2b_count", 70'(dn), 70'(3));

    // reset in the middle of converting 200
    @(negedge clk);
    start = 1'b1; bin = 8'd200;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_busy", 70'(busy1), 70'(0));
    chk("mid_done", 70'(done1), 70'(0));
    chk("mid_bcd",  70'(bcd1),  70'(0));
    chk("mid_seg",  70'(seg1),  70'(21'h1FFFFF));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done1) dn++;
    end
    chk("mid_nodone", 70'(dn), 70'(0));
    convert(8'd42, 0, lat);
    chk("lat42",  70'(lat),  70'(9));
    chk("bcd42",  70'(bcd1), 70'(12'h042));

    // randomized traffic with occasional resets
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 5))
        0:       bin = 8'd0;
        1:       bin = 8'd99;
        2:       bin = 8'd100;
        default: bin = 8'($urandom);
      endcase
      rst_n = ($urandom_range(0, 299) != 0);
    end
    @(negedge clk);
    start = 1'b0; rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
